// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the RX framer and the Ethernet encapsulator:
// FIFO beat layout, header field constants and header decode helpers.
package pcie_tlp_pkg;

    localparam int TLP_LEN          = 11;
    localparam int TLP_TAG_W        = 8;
    localparam int TLP_FMT_4DW_BIT  = 0;
    localparam int TLP_FMT_DATA_BIT = 1;

    localparam logic [4:0] TLP_TYPE_CPL = 5'b01010;

    typedef struct packed {
        logic                 tvalid;
        logic                 tlast;
        logic [7:0]           tkeep;
        logic [63:0]          tdata;
        logic [21:0]          tuser;
        logic [TLP_LEN-1:0]   tlp_len;
        logic [TLP_TAG_W-1:0] tlp_tag;
    } PCIE_FIFO64_RX;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DROP   = 3'd4
    } rx_state_e;

    // Header plus payload bytes; payloads above 256 DW are dropped upstream,
    // so the 11-bit truncation never affects a forwarded TLP.
    function automatic logic [TLP_LEN-1:0] tlp_total_len(input logic [2:0] fmt,
                                                         input logic [9:0] len);
        logic [TLP_LEN-1:0] hdr_bytes;
        logic [TLP_LEN-1:0] pay_bytes;
        hdr_bytes = fmt[TLP_FMT_4DW_BIT] ? 11'd16 : 11'd12;
        pay_bytes = fmt[TLP_FMT_DATA_BIT] ? {len[8:0], 2'b00} : 11'd0;
        return hdr_bytes + pay_bytes;
    endfunction

    // Completions carry their tag in DW2, requests in DW1.
    function automatic logic [TLP_TAG_W-1:0] tlp_tag_sel(input logic [31:0] dw0,
                                                         input logic [63:0] beat0,
                                                         input logic [63:0] beat1);
        logic [TLP_TAG_W-1:0] tag;
        if (dw0[28:24] == TLP_TYPE_CPL) begin
            tag = beat1[15:8];
        end else begin
            tag = beat0[47:40];
        end
        return tag;
    endfunction

endpackage

// File: rtl/pcie_tlp_rx_framer_if.sv
// RX AXI4-Stream from the PCIe core plus the write side of the TLP FIFO.
// The framer uses the slave view; the core/FIFO side uses the master view.
interface pcie_tlp_rx_framer_if;
    import pcie_tlp_pkg::*;

    logic          s_axis_rx_tvalid;
    logic          s_axis_rx_tready;
    logic [63:0]   s_axis_rx_tdata;
    logic [7:0]    s_axis_rx_tkeep;
    logic          s_axis_rx_tlast;
    logic [21:0]   s_axis_rx_tuser;
    logic          wr_en;
    PCIE_FIFO64_RX din;
    logic          full;

    modport slave (
        input  s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
               s_axis_rx_tlast, s_axis_rx_tuser, full,
        output s_axis_rx_tready, wr_en, din
    );

    modport master (
        output s_axis_rx_tvalid, s_axis_rx_tdata, s_axis_rx_tkeep,
               s_axis_rx_tlast, s_axis_rx_tuser, full,
        input  s_axis_rx_tready, wr_en, din
    );

endinterface

// File: rtl/pcie_tlp_rx_framer.sv
// Parses TLP headers off the PCIe RX stream and writes each beat to the TLP
// FIFO tagged with the final length and tag, delaying data by one held beat.
module pcie_tlp_rx_framer
    import pcie_tlp_pkg::*;
#(
    parameter int MAX_PAYLOAD_DW = 256
) (
    input  logic                 pcie_clk,
    input  logic                 pcie_rst,
    pcie_tlp_rx_framer_if.slave  rx,
    output logic [31:0]          rx_pkt_count,
    output logic [31:0]          drop_count
);

    rx_state_e            state_q, state_d;
    logic [63:0]          hold_data_q, hold_data_d;
    logic [7:0]           hold_keep_q, hold_keep_d;
    logic [21:0]          hold_user_q, hold_user_d;
    logic                 hold_last_q, hold_last_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [TLP_LEN-1:0]   len_q, len_d;
    logic [TLP_TAG_W-1:0] tag_q, tag_d;
    logic [31:0]          rx_cnt_q, rx_cnt_d;
    logic [31:0]          drop_cnt_q, drop_cnt_d;

    logic                 tready_s;
    logic                 accept_s;
    logic                 wr_en_s;
    logic                 load_s;
    logic [TLP_TAG_W-1:0] tag_s;
    logic [2:0]           fmt_s;
    logic [9:0]           len_s;
    logic                 oversize_s;
    PCIE_FIFO64_RX        din_s;

    assign fmt_s      = rx.s_axis_rx_tdata[31:29];
    assign len_s      = rx.s_axis_rx_tdata[9:0];
    assign oversize_s = fmt_s[TLP_FMT_DATA_BIT] &
                        ((len_s == 10'd0) | ({22'd0, len_s} > 32'(MAX_PAYLOAD_DW)));

    // Input ready per state; nothing is accepted while in reset.
    always_comb begin
        tready_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DROP:   tready_s = 1'b1;
            ST_HOLD, ST_STREAM: tready_s = ~rx.full;
            default:            tready_s = 1'b0;
        endcase
        if (pcie_rst) begin
            tready_s = 1'b0;
        end else begin
            tready_s = tready_s;
        end
    end

    assign accept_s = rx.s_axis_rx_tvalid & tready_s;

    // Next-state, hold-register and counter updates.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_keep_d = hold_keep_q;
        hold_user_d = hold_user_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        len_d       = len_q;
        tag_d       = tag_q;
        rx_cnt_d    = rx_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_en_s     = 1'b0;
        load_s      = 1'b0;
        tag_s       = tag_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s && rx.s_axis_rx_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end else if (accept_s) begin
                    load_s  = 1'b1;
                    len_d   = tlp_total_len(fmt_s, len_s);
                    tag_d   = 8'd0;
                    state_d = oversize_s ? ST_DROP : ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Beat 1 is in hand, so a completion tag is now known.
                if (accept_s) begin
                    tag_s   = tlp_tag_sel(hold_data_q[31:0], hold_data_q, rx.s_axis_rx_tdata);
                    tag_d   = tag_s;
                    wr_en_s = hold_vld_q;
                    load_s  = 1'b1;
                    state_d = rx.s_axis_rx_tlast ? ST_FLUSH : ST_STREAM;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_STREAM: begin
                if (accept_s) begin
                    wr_en_s = hold_vld_q;
                    load_s  = 1'b1;
                    state_d = rx.s_axis_rx_tlast ? ST_FLUSH : ST_STREAM;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (!rx.full) begin
                    wr_en_s    = hold_vld_q;
                    hold_vld_d = 1'b0;
                    rx_cnt_d   = rx_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DROP: begin
                if (accept_s && rx.s_axis_rx_tlast) begin
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            hold_data_d = rx.s_axis_rx_tdata;
            hold_keep_d = rx.s_axis_rx_tkeep;
            hold_user_d = rx.s_axis_rx_tuser;
            hold_last_d = rx.s_axis_rx_tlast;
            hold_vld_d  = 1'b1;
        end else begin
            hold_vld_d = hold_vld_d;
        end
    end

    // State, hold register and counters.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q     <= ST_IDLE;
            hold_data_q <= 64'd0;
            hold_keep_q <= 8'd0;
            hold_user_q <= 22'd0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            len_q       <= 11'd0;
            tag_q       <= 8'd0;
            rx_cnt_q    <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_user_q <= hold_user_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            len_q       <= len_d;
            tag_q       <= tag_d;
            rx_cnt_q    <= rx_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // FIFO beat: the held beat with its packet metadata.
    always_comb begin
        din_s = '0;
        if (!pcie_rst) begin
            din_s.tvalid  = wr_en_s;
            din_s.tlast   = hold_last_q;
            din_s.tkeep   = hold_keep_q;
            din_s.tdata   = hold_data_q;
            din_s.tuser   = hold_user_q;
            din_s.tlp_len = len_q;
            din_s.tlp_tag = tag_s;
        end else begin
            din_s = '0;
        end
    end

    assign rx.s_axis_rx_tready = tready_s;
    assign rx.wr_en            = wr_en_s & ~pcie_rst;
    assign rx.din              = din_s;
    assign rx_pkt_count        = rx_cnt_q;
    assign drop_count          = drop_cnt_q;

endmodule

// File: tb/tb_pcie_tlp_rx_framer.sv
// Directed bench for pcie_tlp_rx_framer: expected FIFO beats are queued as
// beats are accepted and compared when the framer writes them.
module tb_pcie_tlp_rx_framer;
    import pcie_tlp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_pkt_count;
    logic [31:0] drop_count;

    int checks = 0;
    int errors = 0;
    int exp_rx = 0;
    int exp_drop = 0;

    PCIE_FIFO64_RX sb[$];

    logic [63:0] bd[8];
    logic [7:0]  bk[8];
    logic [21:0] bu[8];

    pcie_tlp_rx_framer_if rxif ();

    pcie_tlp_rx_framer #(.MAX_PAYLOAD_DW(256)) dut (
        .pcie_clk     (clk),
        .pcie_rst     (rst),
        .rx           (rxif.slave),
        .rx_pkt_count (rx_pkt_count),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score any FIFO write, then step past the rising edge.
    task automatic tick(output bit acc, output bit wr, output bit rdy);
        PCIE_FIFO64_RX exp_b;
        @(negedge clk);
        rdy = rxif.s_axis_rx_tready;
        wr  = rxif.wr_en;
        acc = rxif.s_axis_rx_tvalid & rdy;
        if (wr) begin
            checks++;
            assert (!rxif.full) else begin
                errors++;
                $error("FAIL wr_while_full observed=1 expected=0");
            end
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%h expected=none", rxif.din);
            end
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                checks++;
                assert (rxif.din === exp_b) else begin
                    errors++;
                    $error("FAIL din observed=%h expected=%h", rxif.din, exp_b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic PCIE_FIFO64_RX mk(input int i, input int nb, input logic [10:0] elen,
                                         input logic [7:0] etag);
        PCIE_FIFO64_RX b;
        b.tvalid  = 1'b1;
        b.tlast   = (i == nb - 1);
        b.tkeep   = bk[i];
        b.tdata   = bd[i];
        b.tuser   = bu[i];
        b.tlp_len = elen;
        b.tlp_tag = etag;
        return b;
    endfunction

    function automatic logic [63:0] hdr(input logic [2:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] len, input logic [7:0] tag);
        return {16'hBEEF, tag, 8'h0F, fmt, typ, 14'd0, len};
    endfunction

    // Sends beats 0..nsend-1 of an nb-beat TLP in bd/bk/bu; optional 5-cycle full stall before beat stall_at.
    task automatic send_pkt(input int nb, input int nsend, input bit fwd,
                            input logic [10:0] elen, input logic [7:0] etag, input int stall_at);
        bit acc, wr, rdy;
        int n;
        for (int i = 0; i < nsend; i++) begin
            rxif.s_axis_rx_tvalid = 1'b1;
            rxif.s_axis_rx_tdata  = bd[i];
            rxif.s_axis_rx_tkeep  = bk[i];
            rxif.s_axis_rx_tuser  = bu[i];
            rxif.s_axis_rx_tlast  = (i == nb - 1);
            if (i == stall_at) begin
                rxif.full = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    tick(acc, wr, rdy);
                    chk("stall_tready", {63'd0, rdy}, 64'd0);
                    chk("stall_wr_en", {63'd0, wr}, 64'd0);
                end
                rxif.full = 1'b0;
            end
            if (fwd && i >= 1) sb.push_back(mk(i - 1, nb, elen, etag));
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                tick(acc, wr, rdy);
                n++;
            end
            if (!acc) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (fwd && i >= 1) chk("write_on_accept", {63'd0, wr}, 64'd1);
            if (!fwd) chk("drop_no_write", {63'd0, wr}, 64'd0);
        end
        rxif.s_axis_rx_tvalid = 1'b0;
        rxif.s_axis_rx_tlast  = 1'b0;
        if (fwd && nsend == nb) begin
            sb.push_back(mk(nb - 1, nb, elen, etag));
            tick(acc, wr, rdy);
            chk("flush_write", {63'd0, wr}, 64'd1);
        end
    endtask

    task automatic fill_payload(input int from, input int nb, input logic [7:0] seed);
        for (int i = from; i < nb; i++) begin
            bd[i] = {seed, 24'h00A5A5, seed ^ 8'(i), 24'h5A5A00};
            bk[i] = 8'hFF;
            bu[i] = {seed[5:0], 16'(i)};
        end
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_rx_count"}, {32'd0, rx_pkt_count}, 64'(exp_rx));
        chk({tag, "_drop_count"}, {32'd0, drop_count}, 64'(exp_drop));
    endtask

    initial begin
        bit acc, wr, rdy;
        rst = 1'b1;
        rxif.s_axis_rx_tvalid = 1'b0;
        rxif.s_axis_rx_tdata  = 64'd0;
        rxif.s_axis_rx_tkeep  = 8'd0;
        rxif.s_axis_rx_tlast  = 1'b0;
        rxif.s_axis_rx_tuser  = 22'd0;
        rxif.full             = 1'b0;
        @(posedge clk);
        #1;
        tick(acc, wr, rdy);
        chk("rst_tready", {63'd0, rdy}, 64'd0);
        chk("rst_wr_en", {63'd0, wr}, 64'd0);
        rst = 1'b0;
        tick(acc, wr, rdy);
        chk("idle_tready", {63'd0, rdy}, 64'd1);
        chk("idle_din", rxif.din[63:0], 64'd0);
        check_counts("reset");

        // MRd32, tag 35, 2 beats
        fill_payload(1, 2, 8'h11);
        bd[0] = hdr(3'b000, 5'b00000, 10'd1, 8'h35); bk[0] = 8'hFF; bu[0] = 22'h12345;
        bk[1] = 8'h0F;
        send_pkt(2, 2, 1'b1, 11'd12, 8'h35, -1);
        exp_rx++;
        check_counts("mrd32");

        // MWr64 len=4, 3 beats
        fill_payload(1, 3, 8'h22);
        bd[0] = hdr(3'b011, 5'b00000, 10'd4, 8'h5C); bk[0] = 8'hFF; bu[0] = 22'h00077;
        send_pkt(3, 3, 1'b1, 11'd32, 8'h5C, -1);
        exp_rx++;
        check_counts("mwr64");

        // CplD len=1, tag in DW2[15:8]
        bd[0] = hdr(3'b010, 5'b01010, 10'd1, 8'h11); bk[0] = 8'hFF; bu[0] = 22'h3FFFF;
        bd[1] = {32'hCAFEF00D, 16'h0100, 8'hA7, 8'h04}; bk[1] = 8'hFF; bu[1] = 22'h00001;
        send_pkt(2, 2, 1'b1, 11'd16, 8'hA7, -1);
        exp_rx++;
        check_counts("cpld");

        // MWr32 len=300 dropped
        fill_payload(1, 3, 8'h33);
        bd[0] = hdr(3'b010, 5'b00000, 10'd300, 8'h01); bk[0] = 8'hFF; bu[0] = 22'd0;
        send_pkt(3, 3, 1'b0, 11'd0, 8'h00, -1);
        exp_drop++;
        check_counts("drop300");

        // MWr32 len=0 (1024 DW) dropped
        fill_payload(1, 2, 8'h44);
        bd[0] = hdr(3'b010, 5'b00000, 10'd0, 8'h02); bk[0] = 8'hFF; bu[0] = 22'd0;
        send_pkt(2, 2, 1'b0, 11'd0, 8'h00, -1);
        exp_drop++;
        check_counts("drop0");

        // MRd after drops forwarded normally
        fill_payload(1, 2, 8'h55);
        bd[0] = hdr(3'b000, 5'b00000, 10'd2, 8'h6E); bk[0] = 8'hFF; bu[0] = 22'h2AAAA;
        send_pkt(2, 2, 1'b1, 11'd12, 8'h6E, -1);
        exp_rx++;
        check_counts("mrd_after_drop");

        // Boundary: len=256 accepted, len=257 dropped
        fill_payload(1, 3, 8'h66);
        bd[0] = hdr(3'b010, 5'b00000, 10'd256, 8'h7B); bk[0] = 8'hFF; bu[0] = 22'h01010;
        send_pkt(3, 3, 1'b1, 11'd1036, 8'h7B, -1);
        exp_rx++;
        bd[0] = hdr(3'b010, 5'b00000, 10'd257, 8'h7C);
        send_pkt(3, 3, 1'b0, 11'd0, 8'h00, -1);
        exp_drop++;
        check_counts("len_boundary");

        // Malformed single-beat TLP
        bd[0] = hdr(3'b000, 5'b00000, 10'd1, 8'h99); bk[0] = 8'hFF; bu[0] = 22'd0;
        send_pkt(1, 1, 1'b0, 11'd0, 8'h00, -1);
        exp_drop++;
        check_counts("malformed");

        // MWr32 len=4, 4 beats, full held for 5 cycles before beat 2
        fill_payload(1, 4, 8'h77);
        bd[0] = hdr(3'b010, 5'b00000, 10'd4, 8'h42); bk[0] = 8'hFF; bu[0] = 22'h00F0F;
        send_pkt(4, 4, 1'b1, 11'd28, 8'h42, 2);
        exp_rx++;
        check_counts("full_stall");

        // Reset pulsed while in STREAM with a beat held
        fill_payload(1, 6, 8'h88);
        bd[0] = hdr(3'b011, 5'b00000, 10'd8, 8'h13); bk[0] = 8'hFF; bu[0] = 22'd5;
        send_pkt(6, 3, 1'b1, 11'd48, 8'h13, -1);
        rst = 1'b1;
        tick(acc, wr, rdy);
        chk("midrst_tready", {63'd0, rdy}, 64'd0);
        chk("midrst_wr_en", {63'd0, wr}, 64'd0);
        rst = 1'b0;
        exp_rx = 0;
        exp_drop = 0;
        tick(acc, wr, rdy);
        chk("postrst_wr_en", {63'd0, wr}, 64'd0);
        chk("postrst_idle_tready", {63'd0, rdy}, 64'd1);
        check_counts("postrst");

        fill_payload(1, 2, 8'h99);
        bd[0] = hdr(3'b001, 5'b00000, 10'd3, 8'hD2); bk[0] = 8'hFF; bu[0] = 22'h11111;
        send_pkt(2, 2, 1'b1, 11'd16, 8'hD2, -1);
        exp_rx++;
        tick(acc, wr, rdy);
        check_counts("after_reset_pkt");
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
